carry_skip_sub_pipe_16bit: RTL and testbench
============================================

# carry_skip_sub_pipe_16bit

Pipelined 16-bit unsigned/two's-complement subtractor computing a − b as a + ~b + 1 through four 4-bit carry-skip blocks, one block per pipeline stage. Each stage ripples its nibble and skips the incoming carry when all four propagate bits are set. The block adds a valid/ready streaming handshake with full-throughput backpressure. It is the subtract-direction counterpart of the 16-bit carry-skip adder and feeds the comparator/difference paths of the benchmark datapath.

## Interface
- No parameters. Width is fixed at 16 bits, split into 4 nibble stages.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block accepts an operand pair this cycle.
- a  input  16  minuend.
- b  input  16  subtrahend.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream accepts the result this cycle.
- diff  output  16  a − b mod 2^16.
- bout  output  1  borrow out, 1 iff a < b unsigned; equal to ~carry out of the top nibble.
- ovf  output  1  signed overflow: (a[15] != b[15]) && (diff[15] != a[15]).
- zero  output  1  diff == 16'h0000.
- occupancy  output  3  number of valid stages, 0..4.

## Operation
- Four stage registers S1..S4. Each holds:
  - a valid bit;
  - the diff nibbles computed so far;
  - the carry into the next nibble;
  - the remaining unprocessed a and ~b nibbles;
  - a running zero-so-far bit.
- Stage k computes nibble k−1:
  - p = a_n ^ ~b_n, bp = &p.
  - Ripple sum and ripple carry-out with the stage carry-in.
  - Stage carry-out = bp ? carry-in : ripple carry-out.
  - S1 carry-in is the constant 1.
- S4 drives diff, bout, ovf and zero directly from registers. ovf uses a[15] and b[15] carried through the stages.
- Advance chain:
  - adv4 = !v4 || out_ready.
  - advk = !vk || adv(k+1), for k = 3..1.
  - in_ready = adv1 (combinational from out_ready and the valid bits).
- Sk loads from S(k−1) when advk. Sk.valid loads S(k−1).valid; S1.valid loads in_valid && in_ready.
- A stage that does not advance holds all of its fields.
- occupancy = v1+v2+v3+v4. It updates in the same edge as the valid bits.
- Results leave strictly in acceptance order. No transaction is dropped or duplicated.

## Timing
- Reset (rst high at an edge):
  - All valid bits, data fields and carries clear to 0.
  - out_valid=0, diff=0, bout=0, ovf=0, zero=0, occupancy=0.
  - in_ready reads 1 during the first cycle after reset.
  - Reset mid-operation discards all in-flight transactions, regardless of out_ready.
- Latency: a pair accepted at edge t (in_valid && in_ready) is presented on the outputs with out_valid=1 after edge t+3. That is 4 cycles counting the accept cycle.
- Throughput: with out_ready held at 1, one result per cycle; in_ready stays 1.
- Backpressure: with out_ready=0 and out_valid=1, outputs hold stable.
  - Upstream stages keep filling until every stage is valid. Then in_ready=0 and occupancy=4.
- Simultaneous handshakes at a full pipeline: when out_ready=1 and occupancy=4, in_ready=1 in the same cycle. Output and input transfers both occur and occupancy stays 4.
- in_valid while in_ready=0: the input is ignored. The source must hold it.
- Arithmetic is fully combinational within a stage, with at most 4 full-adder delays plus one skip mux per cycle.

## Test plan
- Basic: a=16'h1234, b=16'h0234, out_ready=1 → after 4 cycles diff=16'h1000, bout=0, ovf=0, zero=0.
- Borrow and skip:
  - a=16'h0000, b=16'h0001 → diff=16'hFFFF, bout=1, ovf=0.
  - a=16'h5A5A, b=16'h5A5A (every nibble takes the skip path) → diff=16'h0000, zero=1, bout=0.
- Signed overflow:
  - a=16'h8000, b=16'h0001 → diff=16'h7FFF, ovf=1, bout=0.
  - a=16'h7FFF, b=16'hFFFF → diff=16'h8000, ovf=1, bout=1.
- Backpressure:
  - With out_ready=0, offer 6 consecutive pairs → exactly 4 accepted, in_ready=0, occupancy=4, outputs stable.
  - Then raise out_ready → all 6 results emerge in order, one per cycle, with no loss or duplication.
- Streaming: 1000 random pairs, random in_valid/out_ready toggling → every result equals the reference a−b, with flags correct and order preserved.
- Reset mid-flight: accept 3 pairs, assert rst for one cycle → next cycle out_valid=0, occupancy=0, all outputs 0. A new pair yields its correct result 4 cycles after acceptance.

Source files
------------

// File: rtl/carry_skip_sub_pipe_16bit_if.sv
// Streaming bus of the pipelined carry-skip subtractor: operand channel in,
// result channel out, plus the pipeline fill level.
interface carry_skip_sub_pipe_16bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;
  logic [2:0]  occupancy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero, occupancy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero, occupancy
  );
endinterface

// File: rtl/carry_skip_sub_pipe_16bit.sv
// Four-stage pipelined 16-bit subtractor (a + ~b + 1), one 4-bit carry-skip
// block per stage, with a valid/ready stream that sustains one result per cycle.
module carry_skip_sub_pipe_16bit (
  input logic                          clk,
  input logic                          rst,
  carry_skip_sub_pipe_16bit_if.slave   bus
);

  // Ripple one nibble; when all propagate bits are set the incoming carry skips past.
  function automatic logic [4:0] skip_nibble(input logic [3:0] a_n,
                                             input logic [3:0] nb_n,
                                             input logic       cin);
    logic [3:0] p;
    logic [3:0] s;
    logic       c;
    p = a_n ^ nb_n;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      s[i] = p[i] ^ c;
      c    = (a_n[i] & nb_n[i]) | (p[i] & c);
    end
    return {((&p) ? cin : c), s};
  endfunction

  // Each stage keeps only the operand nibbles it has not yet consumed.
  logic        v1_r, v2_r, v3_r, v4_r;
  logic [3:0]  d1_r;
  logic [7:0]  d2_r;
  logic [11:0] d3_r;
  logic [15:0] d4_r;
  logic        c1_r, c2_r, c3_r;
  logic [11:0] a1_r, nb1_r;
  logic [7:0]  a2_r, nb2_r;
  logic [3:0]  a3_r, nb3_r;
  logic        z1_r, z2_r, z3_r, z4_r;
  logic        bout4_r, ovf4_r;
  logic [2:0]  occ_r;

  logic [15:0] nb_in_s;
  logic [4:0]  n1_s, n2_s, n3_s, n4_s;
  logic        adv1_s, adv2_s, adv3_s, adv4_s;
  logic        v1_nxt_s, v2_nxt_s, v3_nxt_s, v4_nxt_s;

  // Advance chain, per-stage nibble arithmetic and next valid bits.
  always_comb begin
    adv4_s   = !v4_r || bus.out_ready;
    adv3_s   = !v3_r || adv4_s;
    adv2_s   = !v2_r || adv3_s;
    adv1_s   = !v1_r || adv2_s;
    nb_in_s  = ~bus.b;
    n1_s     = skip_nibble(bus.a[3:0], nb_in_s[3:0], 1'b1);
    n2_s     = skip_nibble(a1_r[3:0], nb1_r[3:0], c1_r);
    n3_s     = skip_nibble(a2_r[3:0], nb2_r[3:0], c2_r);
    n4_s     = skip_nibble(a3_r, nb3_r, c3_r);
    v1_nxt_s = adv1_s ? (bus.in_valid && adv1_s) : v1_r;
    v2_nxt_s = adv2_s ? v1_r : v2_r;
    v3_nxt_s = adv3_s ? v2_r : v3_r;
    v4_nxt_s = adv4_s ? v3_r : v4_r;
  end

  // Stage registers: reset clears everything, otherwise load on advance or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r <= 1'b0; v2_r <= 1'b0; v3_r <= 1'b0; v4_r <= 1'b0;
      d1_r <= 4'h0; d2_r <= 8'h00; d3_r <= 12'h000; d4_r <= 16'h0000;
      c1_r <= 1'b0; c2_r <= 1'b0; c3_r <= 1'b0;
      a1_r <= 12'h000; nb1_r <= 12'h000;
      a2_r <= 8'h00;   nb2_r <= 8'h00;
      a3_r <= 4'h0;    nb3_r <= 4'h0;
      z1_r <= 1'b0; z2_r <= 1'b0; z3_r <= 1'b0; z4_r <= 1'b0;
      bout4_r <= 1'b0;
      ovf4_r  <= 1'b0;
      occ_r   <= 3'd0;
    end else begin
      v1_r <= v1_nxt_s;
      v2_r <= v2_nxt_s;
      v3_r <= v3_nxt_s;
      v4_r <= v4_nxt_s;
      occ_r <= {2'b00, v1_nxt_s} + {2'b00, v2_nxt_s} + {2'b00, v3_nxt_s} + {2'b00, v4_nxt_s};
      if (adv1_s) begin
        a1_r  <= bus.a[15:4];
        nb1_r <= nb_in_s[15:4];
        d1_r  <= n1_s[3:0];
        c1_r  <= n1_s[4];
        z1_r  <= (n1_s[3:0] == 4'h0);
      end
      if (adv2_s) begin
        a2_r  <= a1_r[11:4];
        nb2_r <= nb1_r[11:4];
        d2_r  <= {n2_s[3:0], d1_r};
        c2_r  <= n2_s[4];
        z2_r  <= z1_r && (n2_s[3:0] == 4'h0);
      end
      if (adv3_s) begin
        a3_r  <= a2_r[7:4];
        nb3_r <= nb2_r[7:4];
        d3_r  <= {n3_s[3:0], d2_r};
        c3_r  <= n3_s[4];
        z3_r  <= z2_r && (n3_s[3:0] == 4'h0);
      end
      // Flags are finalised here so every output comes straight from a register.
      if (adv4_s) begin
        d4_r    <= {n4_s[3:0], d3_r};
        z4_r    <= z3_r && (n4_s[3:0] == 4'h0);
        bout4_r <= ~n4_s[4];
        ovf4_r  <= (a3_r[3] != ~nb3_r[3]) && (n4_s[3] != a3_r[3]);
      end
    end
  end

  assign bus.in_ready  = adv1_s;
  assign bus.out_valid = v4_r;
  assign bus.diff      = d4_r;
  assign bus.bout      = bout4_r;
  assign bus.ovf       = ovf4_r;
  assign bus.zero      = z4_r;
  assign bus.occupancy = occ_r;

endmodule

// File: tb/tb_carry_skip_sub_pipe_16bit.sv
// Bench for carry_skip_sub_pipe_16bit: directed vector table with exact latency,
// backpressure, random streaming against a scoreboard, and mid-flight reset.
module tb_carry_skip_sub_pipe_16bit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  carry_skip_sub_pipe_16bit_if bus ();

  carry_skip_sub_pipe_16bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t        vecs [10];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [15:0] qa [$];
  logic [15:0] qb [$];
  int          emitted   = 0;
  logic [2:0]  g_occ;

  // Reference: plain two's-complement subtraction with flags from their definitions.
  function automatic logic [18:0] ref_model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    d = a - b;
    return {(a < b), ((a[15] != b[15]) && (d[15] != a[15])), (d == 16'h0000), d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // One clock: sample handshakes at negedge, score results, then step past posedge.
  task automatic tick(output bit acc, output bit em);
    logic [15:0] ea, eb;
    @(negedge clk);
    acc   = bus.in_valid && bus.in_ready;
    em    = bus.out_valid && bus.out_ready;
    g_occ = bus.occupancy;
    if (em) begin
      emitted++;
      if (qa.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk($sformatf("result_%h_minus_%h", ea, eb),
            {13'd0, bus.bout, bus.ovf, bus.zero, bus.diff}, {13'd0, ref_model(ea, eb)});
      end
    end
    if (acc) begin
      qa.push_back(bus.a);
      qb.push_back(bus.b);
    end
    @(posedge clk);
    #1;
  endtask

  // Single pair into an empty pipe with out_ready=1; checks exact 4-cycle latency.
  task automatic apply_vec(input vec_t v, input string nm);
    bus.in_valid = 1'b1;
    bus.a = v.a;
    bus.b = v.b;
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({nm, "_early"}, {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({nm, "_result"}, {13'd0, bus.bout, bus.ovf, bus.zero, bus.diff},
        {13'd0, v.bout, v.ovf, v.zero, v.diff});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] bpa [6];
    logic [15:0] bpb [6];
    logic [15:0] held;
    logic [18:0] exp0;
    bit   acc, em, have_pair;
    int   idx, cycles, em6, sent;
    vec_t rv;

    vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{16'h0001, 16'hFFFF, 16'h0002, 1'b1, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_occupancy", {29'd0, bus.occupancy}, 32'd0);
    chk("rst_outputs", {13'd0, bus.bout, bus.ovf, bus.zero, bus.diff}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 10; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: six pairs offered with out_ready low
    bpa = '{16'h0010, 16'h1234, 16'h8000, 16'hABCD, 16'h0000, 16'h7FFF};
    bpb = '{16'h0001, 16'h4321, 16'h7FFF, 16'hABCD, 16'hFFFF, 16'h8000};
    bus.out_ready = 1'b0;
    idx = 0;
    repeat (8) begin
      bus.in_valid = (idx < 6);
      bus.a = (idx < 6) ? bpa[idx] : 16'h0000;
      bus.b = (idx < 6) ? bpb[idx] : 16'h0000;
      tick(acc, em);
      if (acc) idx++;
    end
    exp0 = ref_model(bpa[0], bpb[0]);
    @(negedge clk);
    chk("bp_accepted", idx, 32'd4);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_occupancy", {29'd0, bus.occupancy}, 32'd4);
    chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_head", {16'd0, bus.diff}, {16'd0, exp0[15:0]});
    held = bus.diff;
    @(posedge clk);
    #1;
    tick(acc, em);
    tick(acc, em);
    @(negedge clk);
    chk("bp_stable", {16'd0, bus.diff}, {16'd0, held});
    bus.out_ready = 1'b1;
    #1;
    chk("bp_full_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    // the edge above already moved one result and one new pair; score them
    qa.pop_front(); qb.pop_front();
    qa.push_back(bpa[4]); qb.push_back(bpb[4]);
    idx = 5;
    @(negedge clk);
    chk("bp_occ_stays_full", {29'd0, bus.occupancy}, 32'd4);
    @(posedge clk);
    #1;
    // rewind: replay the drain through the scoreboard from a fresh fill
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete(); qb.delete();
    bus.out_ready = 1'b0;
    idx = 0;
    repeat (6) begin
      bus.in_valid = (idx < 6);
      bus.a = (idx < 6) ? bpa[idx] : 16'h0000;
      bus.b = (idx < 6) ? bpb[idx] : 16'h0000;
      tick(acc, em);
      if (acc) idx++;
    end
    bus.out_ready = 1'b1;
    emitted = 0;
    cycles  = 0;
    em6     = 0;
    while ((qa.size() > 0 || idx < 6) && cycles < 20) begin
      bus.in_valid = (idx < 6);
      bus.a = (idx < 6) ? bpa[idx] : 16'h0000;
      bus.b = (idx < 6) ? bpb[idx] : 16'h0000;
      tick(acc, em);
      if (acc) idx++;
      if (em && cycles < 6) em6++;
      cycles++;
      if (cycles == 2) chk("drain_occ_full", {29'd0, g_occ}, 32'd4);
    end
    bus.in_valid = 1'b0;
    chk("drain_total", emitted, 32'd6);
    chk("drain_one_per_cycle", em6, 32'd6);

    // Random streaming with random valid/ready
    emitted   = 0;
    sent      = 0;
    have_pair = 1'b0;
    cycles    = 0;
    while ((sent < 1000 || qa.size() > 0) && cycles < 8000) begin
      if (!have_pair && sent < 1000 && $urandom_range(0, 3) != 0) begin
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        have_pair = 1'b1;
      end
      bus.in_valid  = have_pair;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick(acc, em);
      if (acc) begin
        have_pair = 1'b0;
        sent++;
      end
      cycles++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", emitted, 32'd1000);

    // Reset mid-flight
    repeat (4) tick(acc, em);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'h1111 * 16'(i + 1);
      bus.b = 16'h0101;
      tick(acc, em);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete(); qb.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_occupancy", {29'd0, bus.occupancy}, 32'd0);
    chk("mid_rst_outputs", {13'd0, bus.bout, bus.ovf, bus.zero, bus.diff}, 32'd0);
    @(posedge clk);
    #1;
    rv = '{16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    apply_vec(rv, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
